mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V 32-bit pipeline, directly upstream of WB.
- Takes EX/MEM results and performs loads and stores on the data-memory bus, using a request/ack handshake with variable latency.
- Sign/zero-extends load data and holds the MEM/WB pipeline register that drives WB inputs ctrl_wb, pc4_wb, mem_data, alu_data and rd_wb.
- Stalls upstream while a memory access is outstanding.

Parameters:
- TIMEOUT, 255: max cycles spent in WAIT before the access is abandoned with bus_err.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_mem  in  1  EX/MEM holds a valid instruction.
- ctrl_wb_mem  in  3  WB control: [0] reg write; [2:1] select, 00 alu, 01 mem, 1x pc4.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store. mem_read and mem_write are never both 1.
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- alu_result  in  32  effective address / ALU result.
- store_data  in  32  rs2 value for stores.
- pc4_mem  in  32  PC+4.
- rd_mem  in  32  destination register index.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address, {alu_result[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read word, valid with dmem_ack.
- dmem_ack  in  1  access complete this cycle.
- stall_mem  out  1  hold IF..EX/MEM this cycle.
- misalign_err  out  1  one-cycle registered pulse.
- bus_err  out  1  one-cycle registered pulse.
- ctrl_wb  out  3  to WB.
- pc4_wb  out  32  to WB.
- mem_data  out  32  extended load data to WB.
- alu_data  out  32  to WB.
- rd_wb  out  32  to WB.

Behaviour:
- Reset: all registered outputs 0, state IDLE, counter 0. dmem_req drops immediately on rst_n low, including mid-WAIT. Reset assertion aborts any access; the ack of an aborted access is ignored.
- Memory op: mem_op = valid_mem & (mem_read | mem_write).
- Misalignment: misaligned = h/hu with addr[0]=1, w with addr[1:0]!=0, or funct3 in {011,110,111}.
- Bus outputs (combinational): dmem_req = (IDLE & mem_op & ~misaligned) | WAIT. dmem_we = mem_write. dmem_addr, dmem_be and dmem_wdata are valid whenever req=1. Upstream holds inputs stable while stall_mem=1.
- Store byte enables: sb uses be=0001<<addr[1:0] with wdata={4{sd[7:0]}}. sh uses be=0011<<{addr[1],1'b0} with wdata={2{sd[15:0]}}. sw uses be=1111. For loads be=1111.
- FSM state IDLE:
  - req & ack in the same cycle: zero-wait completion; stall_mem=0; MEM/WB loads at the next edge.
  - req & ~ack: stall_mem=1; go to WAIT; cnt<=1.
- FSM state WAIT:
  - Holds req; stall_mem=1 until ack.
  - On ack: stall_mem=0; MEM/WB loads; go to IDLE; cnt<=0.
  - If cnt==TIMEOUT & ~ack: req drops; stall_mem=0; bus_err=1 next cycle; MEM/WB loads with ctrl_wb[0] forced 0; go to IDLE. Ack in that same cycle wins over timeout.
  - Otherwise cnt increments.
- Misaligned access: no request is issued and stall_mem=0. Next cycle misalign_err=1 and MEM/WB loads with ctrl_wb[0]=0.
- Load extraction (from dmem_rdata shifted by addr lane):
  - lb/lbu: sign/zero-extend byte addr[1:0].
  - lh/lhu: sign/zero-extend halfword addr[1].
  - lw: full word.
  - Non-loads: mem_data<=0.
- MEM/WB register, each edge:
  - If stall_mem=1 or valid_mem=0: bubble (ctrl_wb<=000; other outputs hold).
  - Else: ctrl_wb<=ctrl_wb_mem (bit0 masked on error), pc4_wb<=pc4_mem, alu_data<=alu_result, rd_wb<=rd_mem, mem_data<=extracted.
- Latency: a non-memory op or zero-wait access reaches WB 1 cycle later. An N-wait access reaches WB N+1 cycles later.
- dmem_ack in IDLE with no request is ignored.

Test Plan:
- ALU op (valid, mem_read=mem_write=0, ctrl_wb_mem=001, alu_result=5, pc4=8, rd=3) -> dmem_req=0, stall_mem=0; next cycle ctrl_wb=001, alu_data=5, pc4_wb=8, rd_wb=3.
- lb addr 0x103, rdata 0x80FF_0000 with zero-wait ack -> be=1111, addr=0x100; next cycle mem_data=0xFFFF_FF80, ctrl_wb=011. Same stimulus as lbu -> mem_data=0x80.
- sh addr 0x22, sd=0x1234ABCD, ack after 3 wait cycles -> stall_mem high for 3 cycles, be=1100, wdata=0xABCDABCD, ctrl_wb=000 during the stall, then written through after ack.
- lw addr 0x2 -> dmem_req never asserted; next cycle misalign_err=1 pulse, ctrl_wb[0]=0.
- TIMEOUT=4, no ack -> stall_mem high for 4 cycles, bus_err pulse, write suppressed, IDLE; a later ack is ignored.
- rst_n low mid-WAIT -> dmem_req and all outputs 0 immediately; after release, a new lw with zero-wait ack completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data bus with a variable-latency req/ack handshake,
// extracts and extends load data, and holds the MEM/WB register that feeds writeback.
module mem_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_mem,
  input  logic [2:0]  ctrl_wb_mem,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [31:0] pc4_mem,
  input  logic [31:0] rd_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic        misalign_err,
  output logic        bus_err,
  output logic [2:0]  ctrl_wb,
  output logic [31:0] pc4_wb,
  output logic [31:0] mem_data,
  output logic [31:0] alu_data,
  output logic [31:0] rd_wb
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]  ctrl_wb_q, ctrl_wb_d;
  logic [31:0] pc4_wb_q, pc4_wb_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [31:0] alu_data_q, alu_data_d;
  logic [31:0] rd_wb_q, rd_wb_d;
  logic        misalign_err_q, misalign_err_d;
  logic        bus_err_q, bus_err_d;

  logic        mem_op_s, misaligned_s, req_s, stall_s, timeout_s, mis_err_s, err_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, load_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign mem_op_s = valid_mem & (mem_read | mem_write);

  // Alignment rules by access size; reserved funct3 codes are always rejected
  always_comb begin
    misaligned_s = 1'b0;
    case (funct3)
      3'b001, 3'b101:         misaligned_s = alu_result[0];
      3'b010:                 misaligned_s = (alu_result[1:0] != 2'b00);
      3'b011, 3'b110, 3'b111: misaligned_s = 1'b1;
      default:                misaligned_s = 1'b0;
    endcase
  end

  // Store lane placement: data is replicated so the byte enables select the lane
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = store_data;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          be_s    = 4'b0001 << alu_result[1:0];
          wdata_s = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_s    = 4'b0011 << {alu_result[1], 1'b0};
          wdata_s = {2{store_data[15:0]}};
        end
        default: begin
          be_s    = 4'b1111;
          wdata_s = store_data;
        end
      endcase
    end else begin
      be_s    = 4'b1111;
      wdata_s = store_data;
    end
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    byte_s = 8'h00;
    case (alu_result[1:0])
      2'b00:   byte_s = dmem_rdata[7:0];
      2'b01:   byte_s = dmem_rdata[15:8];
      2'b10:   byte_s = dmem_rdata[23:16];
      2'b11:   byte_s = dmem_rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_s = 32'h0000_0000;
    if (mem_read) begin
      case (funct3)
        3'b000:  load_s = {{24{byte_s[7]}}, byte_s};
        3'b001:  load_s = {{16{half_s[15]}}, half_s};
        3'b010:  load_s = dmem_rdata;
        3'b100:  load_s = {24'h00_0000, byte_s};
        3'b101:  load_s = {16'h0000, half_s};
        default: load_s = 32'h0000_0000;
      endcase
    end else begin
      load_s = 32'h0000_0000;
    end
  end

  // Access FSM: request/ack sequencing, stall generation and timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_s     = 1'b0;
    stall_s   = 1'b0;
    timeout_s = 1'b0;
    mis_err_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_s && misaligned_s) begin
          mis_err_s = 1'b1;
        end else if (mem_op_s) begin
          req_s = 1'b1;
          if (!dmem_ack) begin
            stall_s = 1'b1;
            state_d = WAIT;
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        req_s = 1'b1;
        if (dmem_ack) begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == TIMEOUT_C) begin
          timeout_s = 1'b1;
          state_d   = IDLE;
          cnt_d     = {CNT_W{1'b0}};
        end else begin
          stall_s = 1'b1;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign err_s = mis_err_s | timeout_s;

  // MEM/WB next state: bubbles clear only the control field, data holds
  always_comb begin
    ctrl_wb_d      = ctrl_wb_q;
    pc4_wb_d       = pc4_wb_q;
    mem_data_d     = mem_data_q;
    alu_data_d     = alu_data_q;
    rd_wb_d        = rd_wb_q;
    misalign_err_d = mis_err_s;
    bus_err_d      = timeout_s;
    if (stall_s || !valid_mem) begin
      ctrl_wb_d = 3'b000;
    end else begin
      ctrl_wb_d  = {ctrl_wb_mem[2:1], ctrl_wb_mem[0] & ~err_s};
      pc4_wb_d   = pc4_mem;
      alu_data_d = alu_result;
      rd_wb_d    = rd_mem;
      mem_data_d = err_s ? 32'h0000_0000 : load_s;
    end
  end

  // FSM state and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB pipeline register and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_wb_q      <= 3'b000;
      pc4_wb_q       <= 32'h0000_0000;
      mem_data_q     <= 32'h0000_0000;
      alu_data_q     <= 32'h0000_0000;
      rd_wb_q        <= 32'h0000_0000;
      misalign_err_q <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      ctrl_wb_q      <= ctrl_wb_d;
      pc4_wb_q       <= pc4_wb_d;
      mem_data_q     <= mem_data_d;
      alu_data_q     <= alu_data_d;
      rd_wb_q        <= rd_wb_d;
      misalign_err_q <= misalign_err_d;
      bus_err_q      <= bus_err_d;
    end
  end

  // Bus and stall are gated by reset so an in-flight request vanishes at once
  assign dmem_req   = rst_n & req_s;
  assign stall_mem  = rst_n & stall_s;
  assign dmem_we    = rst_n & mem_write;
  assign dmem_addr  = rst_n ? {alu_result[31:2], 2'b00} : 32'h0000_0000;
  assign dmem_be    = rst_n ? be_s : 4'b0000;
  assign dmem_wdata = rst_n ? wdata_s : 32'h0000_0000;

  assign ctrl_wb      = ctrl_wb_q;
  assign pc4_wb       = pc4_wb_q;
  assign mem_data     = mem_data_q;
  assign alu_data     = alu_data_q;
  assign rd_wb        = rd_wb_q;
  assign misalign_err = misalign_err_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage; expectations come from an arithmetic model of
// load extension, store lanes and the wait/timeout cycle counts.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_mem, mem_read, mem_write, dmem_ack;
  logic [2:0]  ctrl_wb_mem, funct3;
  logic [31:0] alu_result, store_data, pc4_mem, rd_mem, dmem_rdata;
  logic        dmem_req, dmem_we, stall_mem, misalign_err, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, pc4_wb, mem_data, alu_data, rd_wb;
  logic [3:0]  dmem_be;
  logic [2:0]  ctrl_wb;

  int total = 0;
  int bad   = 0;

  logic [2:0] f3_load [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .valid_mem(valid_mem), .ctrl_wb_mem(ctrl_wb_mem),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .alu_result(alu_result), .store_data(store_data), .pc4_mem(pc4_mem), .rd_mem(rd_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_mem(stall_mem), .misalign_err(misalign_err), .bus_err(bus_err),
    .ctrl_wb(ctrl_wb), .pc4_wb(pc4_wb), .mem_data(mem_data), .alu_data(alu_data), .rd_wb(rd_wb)
  );

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * (addr % 4))) % 256;
    h = (word >> (8 * (addr % 4))) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b010:  return word;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic st, input logic [2:0] f3, input logic [31:0] addr);
    if (!st) return 4'hF;
    case (f3 % 4)
      0:       return 4'(1 << (addr % 4));
      1:       return 4'(3 << (addr % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3 % 4)
      0:       return (sd % 256) * 32'h0101_0101;
      1:       return (sd % 65536) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] aligned_addr(input logic [2:0] f3);
    logic [31:0] a;
    int unsigned sz;
    sz = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
    a  = $urandom;
    return a - (a % sz);
  endfunction

  task automatic drive_idle();
    valid_mem = 1'b0; mem_read = 1'b0; mem_write = 1'b0; ctrl_wb_mem = 3'b000;
    funct3 = 3'b000; alu_result = 32'h0; store_data = 32'h0; pc4_mem = 32'h0;
    rd_mem = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
  endtask

  task automatic drive_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                          input logic [2:0] c, input logic [31:0] a, input logic [31:0] sd);
    valid_mem = 1'b1; mem_read = rd_op; mem_write = wr_op; funct3 = f3; ctrl_wb_mem = c;
    alu_result = a; store_data = sd; pc4_mem = $urandom; rd_mem = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_op(1'b1, 1'b0, 3'b010, 3'b011, 32'h40, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({dmem_req, stall_mem, dmem_we, dmem_be} !== 7'h00)
      $display("FAIL reset_bus got=%h exp=00", {dmem_req, stall_mem, dmem_we, dmem_be});
    if ({dmem_req, stall_mem, dmem_we, dmem_be} !== 7'h00) bad++;
    total++;
    if ({ctrl_wb, pc4_wb, mem_data, alu_data, rd_wb, misalign_err, bus_err} !== 133'h0) begin
      bad++;
      $display("FAIL reset_regs got=%h exp=0", {ctrl_wb, pc4_wb, mem_data, alu_data, rd_wb, misalign_err, bus_err});
    end
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    logic [2:0] c;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      c = (i == 0) ? 3'b001 : 3'($urandom);
      a = (i == 0) ? 32'd5 : $urandom;
      drive_op(1'b0, 1'b0, 3'($urandom), c, a, $urandom);
      if (i == 0) begin pc4_mem = 32'd8; rd_mem = 32'd3; end
      dmem_ack = 1'($urandom);
      #3;
      total++;
      if ({dmem_req, stall_mem} !== 2'b00) begin
        bad++; $display("FAIL alu_bus i=%0d got=%b exp=00", i, {dmem_req, stall_mem});
      end
      @(posedge clk); #1;
      total++;
      if ({ctrl_wb, alu_data, pc4_wb, rd_wb, mem_data} !== {c, a, pc4_mem, rd_mem, 32'h0}) begin
        bad++;
        $display("FAIL alu_wb i=%0d got=%h exp=%h", i, {ctrl_wb, alu_data, pc4_wb, rd_wb, mem_data},
                 {c, a, pc4_mem, rd_mem, 32'h0});
      end
    end
    drive_idle();
  endtask

  task automatic test_load_zero_wait();
    logic [2:0] f3, c;
    logic [31:0] a, w;
    for (int i = 0; i < 10; i++) begin
      if (i < 2) begin
        f3 = (i == 0) ? 3'b000 : 3'b100; a = 32'h103; w = 32'h80FF_0000; c = 3'b011;
      end else begin
        f3 = f3_load[$urandom_range(0, 4)]; a = aligned_addr(f3); w = $urandom; c = 3'($urandom);
      end
      drive_op(1'b1, 1'b0, f3, c, a, $urandom);
      dmem_rdata = w; dmem_ack = 1'b1;
      #3;
      total++;
      if ({dmem_req, dmem_we, dmem_be, dmem_addr, stall_mem} !== {1'b1, 1'b0, 4'hF, a & 32'hFFFF_FFFC, 1'b0}) begin
        bad++;
        $display("FAIL load_bus i=%0d got=%h exp=%h", i, {dmem_req, dmem_we, dmem_be, dmem_addr, stall_mem},
                 {1'b1, 1'b0, 4'hF, a & 32'hFFFF_FFFC, 1'b0});
      end
      @(posedge clk); #1;
      total++;
      if ({ctrl_wb, mem_data, alu_data} !== {c, ref_load(f3, a, w), a}) begin
        bad++;
        $display("FAIL load_wb i=%0d f3=%b got=%h exp=%h", i, f3, {ctrl_wb, mem_data, alu_data},
                 {c, ref_load(f3, a, w), a});
      end
    end
    drive_idle();
  endtask

  task automatic test_wait_access();
    logic st;
    logic [2:0] f3, c;
    logic [31:0] a, sd, w;
    int n;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        st = 1'b1; f3 = 3'b001; a = 32'h22; sd = 32'h1234_ABCD; n = 3; c = 3'b000;
      end else begin
        st = 1'($urandom); f3 = st ? 3'($urandom_range(0, 2)) : f3_load[$urandom_range(0, 4)];
        a = aligned_addr(f3); sd = $urandom; c = 3'($urandom); n = $urandom_range(1, TO);
      end
      w = $urandom;
      drive_op(~st, st, f3, c, a, sd);
      for (int k = 0; k < n; k++) begin
        #3;
        total++;
        if ({dmem_req, stall_mem, dmem_we, dmem_be, dmem_addr} !==
            {1'b1, 1'b1, st, ref_be(st, f3, a), a & 32'hFFFF_FFFC}) begin
          bad++;
          $display("FAIL wait_bus i=%0d k=%0d got=%h exp=%h", i, k, {dmem_req, stall_mem, dmem_we, dmem_be, dmem_addr},
                   {1'b1, 1'b1, st, ref_be(st, f3, a), a & 32'hFFFF_FFFC});
        end
        if (st) begin
          total++;
          if (dmem_wdata !== ref_wdata(f3, sd)) begin
            bad++; $display("FAIL wait_wdata i=%0d got=%h exp=%h", i, dmem_wdata, ref_wdata(f3, sd));
          end
        end
        @(posedge clk); #1;
        total++;
        if (ctrl_wb !== 3'b000) begin
          bad++; $display("FAIL wait_bubble i=%0d k=%0d got=%b exp=000", i, k, ctrl_wb);
        end
      end
      dmem_ack = 1'b1; dmem_rdata = w;
      #3;
      total++;
      if ({dmem_req, stall_mem} !== 2'b10) begin
        bad++; $display("FAIL wait_ack i=%0d got=%b exp=10", i, {dmem_req, stall_mem});
      end
      @(posedge clk); #1;
      total++;
      if ({ctrl_wb, mem_data, alu_data, pc4_wb, rd_wb, bus_err} !==
          {c, st ? 32'h0 : ref_load(f3, a, w), a, pc4_mem, rd_mem, 1'b0}) begin
        bad++;
        $display("FAIL wait_wb i=%0d got=%h exp=%h", i, {ctrl_wb, mem_data, alu_data, pc4_wb, rd_wb, bus_err},
                 {c, st ? 32'h0 : ref_load(f3, a, w), a, pc4_mem, rd_mem, 1'b0});
      end
      drive_idle();
    end
  endtask

  task automatic test_misalign();
    logic [2:0]  mf3 [7] = '{3'b010, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011, 3'b110};
    logic [31:0] ma  [7] = '{32'h2, 32'h101, 32'h3, 32'h1, 32'h7, 32'h0, 32'h8};
    logic        mst [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] c;
    for (int i = 0; i < 7; i++) begin
      c = 3'($urandom) | 3'b001;
      drive_op(~mst[i], mst[i], mf3[i], c, ma[i], $urandom);
      #3;
      total++;
      if ({dmem_req, stall_mem} !== 2'b00) begin
        bad++; $display("FAIL mis_bus i=%0d got=%b exp=00", i, {dmem_req, stall_mem});
      end
      @(posedge clk); #1;
      total++;
      if ({misalign_err, bus_err, ctrl_wb} !== {1'b1, 1'b0, c[2:1], 1'b0}) begin
        bad++; $display("FAIL mis_wb i=%0d got=%b exp=%b", i, {misalign_err, bus_err, ctrl_wb}, {1'b1, 1'b0, c[2:1], 1'b0});
      end
      drive_idle();
      @(posedge clk); #1;
      total++;
      if (misalign_err !== 1'b0) begin
        bad++; $display("FAIL mis_pulse i=%0d got=%b exp=0", i, misalign_err);
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] a, w;
    a = aligned_addr(3'b010);
    drive_op(1'b1, 1'b0, 3'b010, 3'b011, a, 32'h0);
    for (int k = 0; k < TO; k++) begin
      #3;
      total++;
      if ({dmem_req, stall_mem} !== 2'b11) begin
        bad++; $display("FAIL to_stall k=%0d got=%b exp=11", k, {dmem_req, stall_mem});
      end
      @(posedge clk); #1;
      total++;
      if ({ctrl_wb, bus_err} !== 4'b0000) begin
        bad++; $display("FAIL to_bubble k=%0d got=%b exp=0000", k, {ctrl_wb, bus_err});
      end
    end
    #3;
    total++;
    if (stall_mem !== 1'b0) begin
      bad++; $display("FAIL to_release got=%b exp=0", stall_mem);
    end
    @(posedge clk); #1;
    total++;
    if ({bus_err, misalign_err, ctrl_wb} !== 5'b10010) begin
      bad++; $display("FAIL to_err got=%b exp=10010", {bus_err, misalign_err, ctrl_wb});
    end
    drive_idle();
    dmem_ack = 1'b1; dmem_rdata = $urandom;
    #3;
    total++;
    if ({dmem_req, stall_mem} !== 2'b00) begin
      bad++; $display("FAIL to_late_ack got=%b exp=00", {dmem_req, stall_mem});
    end
    @(posedge clk); #1;
    total++;
    if ({bus_err, ctrl_wb} !== 4'b0000) begin
      bad++; $display("FAIL to_after got=%b exp=0000", {bus_err, ctrl_wb});
    end
    w = $urandom;
    drive_op(1'b1, 1'b0, 3'b010, 3'b011, a, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = w;
    @(posedge clk); #1;
    total++;
    if ({ctrl_wb, mem_data} !== {3'b011, w}) begin
      bad++; $display("FAIL to_recover got=%h exp=%h", {ctrl_wb, mem_data}, {3'b011, w});
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] a, w;
    a = aligned_addr(3'b010);
    drive_op(1'b1, 1'b0, 3'b010, 3'b011, a, 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({dmem_req, stall_mem, dmem_be} !== 6'h00) begin
      bad++; $display("FAIL rst_wait_bus got=%h exp=00", {dmem_req, stall_mem, dmem_be});
    end
    total++;
    if ({ctrl_wb, pc4_wb, mem_data, alu_data, rd_wb, misalign_err, bus_err} !== 133'h0) begin
      bad++; $display("FAIL rst_wait_regs got=%h exp=0", {ctrl_wb, pc4_wb, mem_data, alu_data, rd_wb, misalign_err, bus_err});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_idle();
    dmem_ack = 1'b1; dmem_rdata = $urandom;
    #3;
    total++;
    if ({dmem_req, stall_mem} !== 2'b00) begin
      bad++; $display("FAIL rst_stale_ack got=%b exp=00", {dmem_req, stall_mem});
    end
    @(posedge clk); #1;
    total++;
    if ({ctrl_wb, mem_data, bus_err} !== 36'h0) begin
      bad++; $display("FAIL rst_stale_wb got=%h exp=0", {ctrl_wb, mem_data, bus_err});
    end
    w = $urandom;
    drive_op(1'b1, 1'b0, 3'b010, 3'b011, a, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = w;
    #3;
    total++;
    if ({dmem_req, stall_mem} !== 2'b10) begin
      bad++; $display("FAIL rst_new_bus got=%b exp=10", {dmem_req, stall_mem});
    end
    @(posedge clk); #1;
    total++;
    if ({ctrl_wb, mem_data, alu_data} !== {3'b011, w, a}) begin
      bad++; $display("FAIL rst_new_wb got=%h exp=%h", {ctrl_wb, mem_data, alu_data}, {3'b011, w, a});
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0] e_ctrl, f3, c;
    logic [31:0] e_pc4, e_alu, e_rd, e_mem, a, w;
    int kind;
    e_ctrl = 3'b000; e_pc4 = 32'h0; e_alu = 32'h0; e_rd = 32'h0; e_mem = 32'h0;
    for (int i = 0; i < 24; i++) begin
      kind = (i == 0) ? 1 : $urandom_range(0, 3);
      c = 3'($urandom); w = $urandom;
      f3 = (kind == 2) ? f3_load[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a = aligned_addr(f3);
      drive_op(kind == 2, kind == 3, f3, c, a, $urandom);
      dmem_rdata = w;
      dmem_ack = (kind >= 2) ? 1'b1 : 1'($urandom);
      if (kind == 0) valid_mem = 1'b0;
      if (kind == 0) begin
        e_ctrl = 3'b000;
      end else begin
        e_ctrl = c; e_pc4 = pc4_mem; e_alu = a; e_rd = rd_mem;
        e_mem = (kind == 2) ? ref_load(f3, a, w) : 32'h0;
      end
      #3;
      total++;
      if (stall_mem !== 1'b0) begin
        bad++; $display("FAIL b2b_stall i=%0d got=%b exp=0", i, stall_mem);
      end
      @(posedge clk); #1;
      total++;
      if ({ctrl_wb, pc4_wb, alu_data, rd_wb, mem_data} !== {e_ctrl, e_pc4, e_alu, e_rd, e_mem}) begin
        bad++;
        $display("FAIL b2b_wb i=%0d kind=%0d got=%h exp=%h", i, kind, {ctrl_wb, pc4_wb, alu_data, rd_wb, mem_data},
                 {e_ctrl, e_pc4, e_alu, e_rd, e_mem});
      end
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    drive_idle();
    test_reset();
    test_alu();
    test_load_zero_wait();
    test_wait_access();
    test_misalign();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
